// File: rtl/circuit1_pipe.sv
// Two-stage pipelined Circuit1 datapath: z = max/min(a+b, a+c), x = a*c - (a+b).
// Valid/ready on both sides; global-stall flow control with two result slots.
module circuit1_pipe #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  input  logic                 sel_min,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     z,
  output logic [2*WIDTH-1:0]   x,
  output logic                 ovf
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready may depend combinationally on out_ready; out_valid is registered.

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Stage 1 state
  logic                 s1_valid_q;
  logic [WIDTH:0]       d_full_q, d_full_d;
  logic [WIDTH:0]       e_full_q, e_full_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 sel_min_q;

  // Output stage state
  logic                 out_valid_q;
  logic [WIDTH-1:0]     z_q, z_d;
  logic [2*WIDTH-1:0]   x_q, x_d;
  logic                 ovf_q, ovf_d;

  logic                 out_load;
  logic                 s1_load;
  logic                 accept;
  logic [2*WIDTH-1:0]   a_ext, c_ext;
  logic                 d_ovf, e_ovf;
  logic [WIDTH-1:0]     d_red, e_red;
  logic                 d_gt_e;

  assign out_load = !out_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || out_load;
  assign in_ready = s1_load && Rst;
  assign accept   = in_valid && s1_load;

  // Stage 1 arithmetic: sums one bit wider so overflow is detectable later.
  always_comb begin
    a_ext    = {{WIDTH{a[WIDTH-1]}}, a};
    c_ext    = {{WIDTH{c[WIDTH-1]}}, c};
    d_full_d = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    e_full_d = {a[WIDTH-1], a} + {c[WIDTH-1], c};
    p_d      = a_ext * c_ext;
  end

  // A WIDTH+1 bit sum is out of range exactly when its top two bits differ.
  assign d_ovf = d_full_q[WIDTH] ^ d_full_q[WIDTH-1];
  assign e_ovf = e_full_q[WIDTH] ^ e_full_q[WIDTH-1];

  always_comb begin
    d_red = d_full_q[WIDTH-1:0];
    e_red = e_full_q[WIDTH-1:0];
    if (SATURATE != 0) begin
      if (d_ovf) d_red = d_full_q[WIDTH] ? SMIN : SMAX;
      if (e_ovf) e_red = e_full_q[WIDTH] ? SMIN : SMAX;
    end
  end

  always_comb begin
    d_gt_e = $signed(d_red) > $signed(e_red);
    z_d    = (d_gt_e ^ sel_min_q) ? d_red : e_red;
    x_d    = p_q - {{WIDTH{d_red[WIDTH-1]}}, d_red};
    ovf_d  = d_ovf | e_ovf;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      s1_valid_q <= 1'b0;
      d_full_q   <= '0;
      e_full_q   <= '0;
      p_q        <= '0;
      sel_min_q  <= 1'b0;
    end else begin
      if (s1_load) s1_valid_q <= in_valid;
      if (accept) begin
        d_full_q  <= d_full_d;
        e_full_q  <= e_full_d;
        p_q       <= p_d;
        sel_min_q <= sel_min;
      end
    end
  end

  // Output data only changes when a new valid result moves in, so a stalled
  // result stays stable.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      out_valid_q <= 1'b0;
      z_q         <= '0;
      x_q         <= '0;
      ovf_q       <= 1'b0;
    end else if (out_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        z_q   <= z_d;
        x_q   <= x_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign x         = x_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/circuit1_pipe.md
Name: circuit1_pipe

Overview:
- Parametrised, pipelined successor to the generated Circuit1 datapath. It computes z = select(a+b, a+c) and x = a*c − (a+b) at configurable width.
- Adds a valid/ready handshake with backpressure, a min/max select mode, optional saturation of the sums, and an overflow flag.
- Sits between an upstream operand source and a downstream consumer in the generated datapath; drop-in where a registered Circuit1 result is needed at sustained throughput.

Parameters:
- WIDTH, 8, operand width in bits (≥2); x is 2*WIDTH bits.
- SATURATE, 0, 0 = sums wrap modulo 2^WIDTH; 1 = sums clamp to the signed WIDTH range.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands a/b/c/sel_min are valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  signed operand.
- b  input  WIDTH  signed operand.
- c  input  WIDTH  signed operand.
- sel_min  input  1  0: z = max(d,e); 1: z = min(d,e). Captured with the operands.
- out_valid  output  1  z/x/ovf hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- z  output  WIDTH  signed selected sum.
- x  output  2*WIDTH  signed a*c − d.
- ovf  output  1  d or e wrapped or clamped.

Behaviour:
- Clock and reset: one clock, Clk; reset Rst is asynchronous, active-low.
- Reset (Rst=0, asynchronous):
  - s1_valid and out_valid = 0; z, x, ovf and all pipeline data registers = 0.
  - in_ready = 0 while Rst=0; in_ready = 1 in the first cycle after release.
  - A reset mid-operation discards all in-flight results; nothing is replayed.
- Transfers: input accepted on in_valid && in_ready at a rising edge; output consumed on out_valid && out_ready.
- Stage 1 register (s1), loaded on accept:
  - d_full = a+b and e_full = a+c at WIDTH+1 bits.
  - p = a*c at 2*WIDTH signed.
  - sel_min is carried with the data.
- Width reduction (combinational, on s1 data):
  - SATURATE=0: d = d_full[WIDTH-1:0], same for e (wrap).
  - SATURATE=1: clamp to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - ovf = 1 if d_full or e_full lies outside the signed WIDTH range.
- Stage 2 / output register, loaded from s1:
  - z = (d>e)^sel_min ? d : e, using a signed compare of the reduced WIDTH-bit values; on d==e, z = d.
  - x = p − sign_extend(d) at 2*WIDTH bits; it cannot overflow.
- Latency: 2 cycles. A result is presented on out_valid two rising edges after acceptance when out_ready is high.
- Throughput: 1 result/cycle with out_ready held high.
- Flow control (global stall):
  - out_load = !out_valid || out_ready.
  - Output register loads s1 when out_load; out_valid <= s1_valid on out_load.
  - s1_load = !s1_valid || out_load; in_ready = s1_load.
  - s1_valid <= in_valid on s1_load.
- Capacity: 2 results. With out_ready=0, in_ready drops once both stages hold valid data.
- Stall: while out_valid=1 and out_ready=0, z/x/ovf are held stable.
- Simultaneous consume and accept in one cycle is allowed; no bubble is inserted. Result order is preserved.
- No combinational path from in_valid to out_valid. in_ready depends on out_ready combinationally.

Test Plan:
- WIDTH=8: a=10, b=20, c=5, sel_min=0, out_ready=1 → 2 cycles later z=30, x=20, ovf=0; with sel_min=1 → z=15, x=20.
- SATURATE=0: a=100, b=100, c=−128 → d=−56, e=−28, z=−28, x=−12744, ovf=1. SATURATE=1, same operands → z=127, x=−12927, ovf=1.
- Equal sums: a=0, b=7, c=7, each sel_min → z=7, x=−7, ovf=0.
- Throughput: 8 back-to-back inputs a=i, b=1, c=1 with out_ready=1 → out_valid high 8 consecutive cycles, z=i+1 in order, in_ready constantly 1.
- Backpressure: out_ready=0 and 3 inputs offered → 2 accepted, then in_ready=0. Outputs stay stable for 5 cycles. Raising out_ready → 3 results emerge in order on consecutive cycles.
- Reset mid-flight: pull Rst low asynchronously between edges with 2 results in flight → out_valid, z, x, ovf = 0 immediately. After release, in_ready=1 and no stale result appears.
